// File: rtl/divider_13bits_seq.sv
// Sequential signed fixed-point divider: z = (a <<< 10) / b, S3.9 / S1.10 -> S3.9.
// Restoring radix-2 on magnitudes, one quotient bit per clock, valid/ready in and out.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   operand handshake; a (S3.9), b (S1.10)
//   out_valid/out_ready result handshake; z (S3.9 saturated), ovf, dz
module divider_13bits_seq #(
   parameter int A_W    = 13,
   parameter int B_W    = 12,
   parameter int Z_W    = 13,
   parameter int B_FRAC = 10,
   parameter int ITER   = A_W + B_FRAC
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [A_W-1:0] a,
   input  logic [B_W-1:0] b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [Z_W-1:0] z,
   output logic           ovf,
   output logic           dz
);

   localparam int CW = $clog2(ITER + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   localparam logic [ITER-1:0] QPOS = ITER'((1 << (Z_W - 1)) - 1);
   localparam logic [ITER-1:0] QNEG = ITER'(1 << (Z_W - 1));
   localparam logic [Z_W-1:0]  ZPOS = Z_W'((1 << (Z_W - 1)) - 1);
   localparam logic [Z_W-1:0]  ZNEG = Z_W'(1 << (Z_W - 1));

   state_t          state;
   logic [ITER-1:0] dvd;
   logic [ITER-1:0] quo;
   logic [B_W-1:0]  rem;
   logic [B_W-1:0]  bmag;
   logic [CW-1:0]   cnt;
   logic            neg;
   logic            aneg;
   logic            zdiv;

   logic [A_W-1:0]  amag;
   logic [B_W-1:0]  bmag_in;
   logic [B_W:0]    sh;
   logic [B_W+1:0]  diff;
   logic            borrow;
   logic [B_W-1:0]  rem_nx;
   logic [Z_W-1:0]  zres;
   logic            ores;
   logic            unused_ok;

   // Magnitudes are unsigned, so -4096 and -2048 map to 4096 and 2048.
   assign amag    = a[A_W-1] ? (~a + 1'b1) : a;
   assign bmag_in = b[B_W-1] ? (~b + 1'b1) : b;

   // Remainder stays below |b| <= 2048, so only its low bits carry state.
   assign sh     = {rem, dvd[ITER-1]};
   assign diff   = {1'b0, sh} - {2'b00, bmag};
   assign borrow = diff[B_W+1];
   assign rem_nx = borrow ? sh[B_W-1:0] : diff[B_W-1:0];

   assign unused_ok = ^{sh[B_W], diff[B_W]};

   always_comb begin
      zres = '0;
      ores = 1'b0;
      if (neg) begin
         if (quo > QNEG) begin
            zres = ZNEG;
            ores = 1'b1;
         end else begin
            zres = ~quo[Z_W-1:0] + 1'b1;
         end
      end else begin
         if (quo > QPOS) begin
            zres = ZPOS;
            ores = 1'b1;
         end else begin
            zres = quo[Z_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         dvd       <= '0;
         quo       <= '0;
         rem       <= '0;
         bmag      <= '0;
         cnt       <= '0;
         neg       <= 1'b0;
         aneg      <= 1'b0;
         zdiv      <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         z         <= '0;
         ovf       <= 1'b0;
         dz        <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  dvd      <= {amag, {B_FRAC{1'b0}}};
                  bmag     <= bmag_in;
                  quo      <= '0;
                  rem      <= '0;
                  cnt      <= '0;
                  neg      <= a[A_W-1] ^ b[B_W-1];
                  aneg     <= a[A_W-1];
                  zdiv     <= (b == '0);
                  in_ready <= 1'b0;
                  state    <= CALC;
               end
            end
            CALC: begin
               if (zdiv) begin
                  z         <= aneg ? ZNEG : ZPOS;
                  ovf       <= 1'b0;
                  dz        <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else if (cnt == CW'(ITER)) begin
                  z         <= zres;
                  ovf       <= ores;
                  dz        <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  rem <= rem_nx;
                  dvd <= {dvd[ITER-2:0], 1'b0};
                  quo <= {quo[ITER-2:0], ~borrow};
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_13bits_seq.sv
// Directed bench for divider_13bits_seq.
// Hand-computed vectors, immediate assertions, one summary line.
module tb_divider_13bits_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [12:0] a;
   logic [11:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [12:0] z;
   logic        ovf;
   logic        dz;

   int vectors = 0;
   int errs    = 0;

   divider_13bits_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .z         (z),
      .ovf       (ovf),
      .dz        (dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run(input string tag, input logic [12:0] av,
                      input logic [11:0] bv, input int lat,
                      input logic [12:0] ze, input logic oe,
                      input logic de, input bit tog, input bit hold);
      int k;
      int n;
      k = 0;
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check({tag, ".rdy"}, 32'(in_ready), 32'd1);
      a = av;
      b = bv;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = 13'($urandom);
      b = 12'($urandom);
      check({tag, ".busy"}, 32'(in_ready), 32'd0);
      n = 0;
      while (!out_valid && n < 40) begin
         if (tog) in_valid = ~in_valid;
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check({tag, ".lat"}, 32'(n), 32'(lat));
      check({tag, ".z"}, 32'(z), 32'(ze));
      check({tag, ".ovf"}, 32'(ovf), 32'(oe));
      check({tag, ".dz"}, 32'(dz), 32'(de));
      if (hold) begin
         repeat (5) begin
            @(negedge clk);
            check({tag, ".hz"}, {16'(z), 13'd0, ovf, dz, out_valid},
                  {16'(ze), 13'd0, oe, de, 1'b1});
            check({tag, ".hrdy"}, 32'(in_ready), 32'd0);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, ".ack"}, {30'd0, out_valid, in_ready}, 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      repeat (2) @(negedge clk);
      check("rst.rdy", 32'(in_ready), 32'd1);
      check("rst.out", {16'(z), 13'd0, ovf, dz, out_valid}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run("t1", 13'd512, 12'd512, 24, 13'd1024, 1'b0, 1'b0, 1'b0, 1'b0);
      run("t2a", -13'sd768, 12'd1024, 24, -13'sd768, 1'b0, 1'b0, 1'b0, 1'b0);
      run("t2b", 13'd1, 12'd3, 24, 13'd341, 1'b0, 1'b0, 1'b0, 1'b0);
      run("t2c", -13'sd1, 12'd3, 24, -13'sd341, 1'b0, 1'b0, 1'b0, 1'b0);
      run("t3a", 13'd2048, 12'd256, 24, 13'd4095, 1'b1, 1'b0, 1'b0, 1'b0);
      run("t3b", 13'h1000, 12'd1, 24, 13'h1000, 1'b1, 1'b0, 1'b0, 1'b0);
      run("t3c", 13'h1000, 12'h800, 24, 13'd2048, 1'b0, 1'b0, 1'b0, 1'b0);
      run("t3d", 13'h1000, 12'd1024, 24, 13'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
      run("t3e", 13'h1000, -12'sd1024, 24, 13'd4095, 1'b1, 1'b0, 1'b0, 1'b0);
      run("t3f", 13'd0, -12'sd7, 24, 13'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      run("t4a", -13'sd5, 12'd0, 1, 13'h1000, 1'b0, 1'b1, 1'b0, 1'b0);
      run("t4b", 13'd7, 12'd0, 1, 13'd4095, 1'b0, 1'b1, 1'b0, 1'b0);
      run("t5", 13'd1, 12'd3, 24, 13'd341, 1'b0, 1'b0, 1'b1, 1'b1);

      a = -13'sd768;
      b = 12'd1024;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t6.rdy", 32'(in_ready), 32'd1);
      check("t6.out", {16'(z), 13'd0, ovf, dz, out_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run("t6", 13'd512, 12'd512, 24, 13'd1024, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
